// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Recovers the four digits shown on a multiplexed, active-low 7-segment
// display by watching its anode and cathode buses. Each anode dwell is
// sampled once the bus has been stable long enough. A complete, in-order
// 0-1-2-3 scan is then published as one frame.
//
// Ports:
//   clk          system clock; all inputs are synchronous to it
//   reset        asynchronous reset, active low
//   an[3:0]      anode bus, active-low one-hot (1110 = digit 0 ... 0111 = digit 3)
//   seg[7:0]     cathode bus, active low; seg[7] = decimal point, seg[6:0] = g..a
//   d0..d3[4:0]  recovered digit codes (31 = undecodable pattern)
//   dp[3:0]      recovered decimal points, active high, bit n = digit n
//   frame_valid  one-cycle pulse when d0..d3/dp take a new frame
//   seq_err      one-cycle pulse when the anode order is broken
//   dec_err      sticky; set by any undecodable sample, cleared by a clean frame
//   stale        high while the anodes have not changed for TIMEOUT cycles
//   dbg_state    current scan state (SYNC/DWELL/WAIT_CHG) for observation
//
// Handshake: frame_valid is a strobe with no back-pressure. d0..d3, dp and
// dec_err are valid in the cycle frame_valid is high. They then hold until
// the next frame_valid or until reset.
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int unsigned SETTLE  = 2,
  parameter logic [19:0] TIMEOUT = 20'd500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] seg,
  output logic [4:0] d0,
  output logic [4:0] d1,
  output logic [4:0] d2,
  output logic [4:0] d3,
  output logic [3:0] dp,
  output logic       frame_valid,
  output logic       seq_err,
  output logic       dec_err,
  output logic       stale,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_SYNC     = 2'd0,
    S_DWELL    = 2'd1,
    S_WAIT_CHG = 2'd2
  } state_t;

  localparam logic [3:0] STAB_MAX = 4'(SETTLE);
  localparam logic [4:0] CODE_BLANK = 5'd23;
  localparam logic [4:0] CODE_BAD   = 5'd31;

  function automatic logic [4:0] decode7(input logic [6:0] p);
    case (p)
      7'h40: decode7 = 5'd0;
      7'h79: decode7 = 5'd1;
      7'h24: decode7 = 5'd2;
      7'h30: decode7 = 5'd3;
      7'h19: decode7 = 5'd4;
      7'h12: decode7 = 5'd5;
      7'h02: decode7 = 5'd6;
      7'h78: decode7 = 5'd7;
      7'h00: decode7 = 5'd8;
      7'h10: decode7 = 5'd9;
      7'h08: decode7 = 5'd10;  // 'A'; the same pattern never maps to 26
      7'h03: decode7 = 5'd11;
      7'h46: decode7 = 5'd12;
      7'h21: decode7 = 5'd13;
      7'h06: decode7 = 5'd14;
      7'h0E: decode7 = 5'd15;
      7'h7E: decode7 = 5'd16;  // single segment a
      7'h7D: decode7 = 5'd17;
      7'h7B: decode7 = 5'd18;
      7'h77: decode7 = 5'd19;
      7'h6F: decode7 = 5'd20;
      7'h5F: decode7 = 5'd21;
      7'h3F: decode7 = 5'd22;  // single segment g
      7'h7F: decode7 = 5'd23;  // blank
      7'h09: decode7 = 5'd24;  // H
      7'h47: decode7 = 5'd25;  // L
      7'h4F: decode7 = 5'd27;  // l
      7'h2F: decode7 = 5'd28;  // r
      default: decode7 = CODE_BAD;
    endcase
  endfunction

  // Active-low anode pattern that digit i drives.
  function automatic logic [3:0] anode_for(input logic [1:0] i);
    anode_for = ~(4'b0001 << i);
  endfunction

  logic [3:0]  an_q;
  logic [7:0]  seg_q;
  logic [11:0] prev_q;
  logic [3:0]  stab_q, stab_d;
  logic [19:0] to_q, to_d;
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [4:0]  shadow_q [4];
  logic [4:0]  shadow_d [4];
  logic [3:0]  shdp_q, shdp_d;
  logic        frame_err_q, frame_err_d;
  logic        dec_err_q, dec_err_d;
  logic        seq_err_q, seq_err_d;
  logic        frame_valid_q;
  logic [4:0]  d0_q, d1_q, d2_q, d3_q;
  logic [3:0]  dp_q;

  logic        an_chg, settled, sample, commit, bad;
  logic [1:0]  samp_idx, idx_nx;
  logic [4:0]  code;

  always_comb begin
    // The stability count reaches SETTLE once {an_q,seg_q} has matched
    // its previous-cycle value SETTLE times in a row.
    stab_d   = 4'd0;
    if ({an_q, seg_q} == prev_q) begin
      stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 4'd1;
    end
    an_chg   = (an_q != prev_q[11:8]);
    to_d     = an_chg ? 20'd0 : ((to_q == TIMEOUT) ? to_q : to_q + 20'd1);
    settled  = (stab_d == STAB_MAX);
    code     = decode7(seg_q[6:0]);
    bad      = (code == CODE_BAD);
    idx_nx   = idx_q + 2'd1;

    state_d   = state_q;
    idx_d     = idx_q;
    sample    = 1'b0;
    seq_err_d = 1'b0;
    case (state_q)
      S_SYNC: begin
        // Bus activity is not an error while hunting for digit 0.
        if (an_q == 4'b1110 && settled) begin
          sample  = 1'b1;
          idx_d   = 2'd0;
          state_d = S_WAIT_CHG;
        end
      end
      S_DWELL: begin
        // Any anode move before the sample aborts the frame.
        // This takes priority over sampling.
        if (an_chg || an_q != anode_for(idx_q)) begin
          seq_err_d = 1'b1;
          state_d   = S_SYNC;
        end else if (settled) begin
          sample  = 1'b1;
          state_d = S_WAIT_CHG;
        end
      end
      S_WAIT_CHG: begin
        // Segment-only changes after the sample are ignored.
        if (an_chg) begin
          if (an_q == anode_for(idx_nx)) begin
            idx_d   = idx_nx;
            state_d = S_DWELL;
          end else begin
            seq_err_d = 1'b1;
            state_d   = S_SYNC;
          end
        end
      end
      default: state_d = S_SYNC;
    endcase

    samp_idx = (state_q == S_SYNC) ? 2'd0 : idx_q;
    commit   = sample && (samp_idx == 2'd3);

    shadow_d    = shadow_q;
    shdp_d      = shdp_q;
    frame_err_d = frame_err_q;
    if (sample) begin
      shadow_d[samp_idx] = code;
      shdp_d[samp_idx]   = ~seg_q[7];
      frame_err_d        = (samp_idx == 2'd0) ? bad : (frame_err_q | bad);
    end

    dec_err_d = dec_err_q;
    if (sample && bad) begin
      dec_err_d = 1'b1;
    end else if (commit && !frame_err_q) begin
      dec_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q          <= 4'hF;
      seg_q         <= 8'hFF;
      prev_q        <= 12'hFFF;
      stab_q        <= 4'd0;
      to_q          <= 20'd0;
      state_q       <= S_SYNC;
      idx_q         <= 2'd0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= CODE_BLANK;
      shdp_q        <= 4'b0000;
      frame_err_q   <= 1'b0;
      dec_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      d0_q          <= CODE_BLANK;
      d1_q          <= CODE_BLANK;
      d2_q          <= CODE_BLANK;
      d3_q          <= CODE_BLANK;
      dp_q          <= 4'b0000;
    end else begin
      an_q          <= an;
      seg_q         <= seg;
      prev_q        <= {an_q, seg_q};
      stab_q        <= stab_d;
      to_q          <= to_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      shdp_q        <= shdp_d;
      frame_err_q   <= frame_err_d;
      dec_err_q     <= dec_err_d;
      seq_err_q     <= seq_err_d;
      frame_valid_q <= commit;
      // Publish from the next-shadow values so digit 3 lands in the same
      // cycle as the other three.
      if (commit) begin
        d0_q <= shadow_d[0];
        d1_q <= shadow_d[1];
        d2_q <= shadow_d[2];
        d3_q <= shadow_d[3];
        dp_q <= shdp_d;
      end
    end
  end

  assign d0          = d0_q;
  assign d1          = d1_q;
  assign d2          = d2_q;
  assign d3          = d3_q;
  assign dp          = dp_q;
  assign frame_valid = frame_valid_q;
  assign seq_err     = seq_err_q;
  assign dec_err     = dec_err_q;
  assign stale       = (to_q == TIMEOUT);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for seg_scan_decoder.
// The reference model works at the level of whole anode dwells.
// Each dwell is (anode value, cathode value, length).
// When the model completes a frame it pushes the expected outputs onto exp_q.
// A negedge monitor pops exp_q on every frame_valid and compares.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

  localparam int          SETTLE = 2;
  localparam logic [19:0] TMO    = 20'd40;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [7:0] seg;
  logic [4:0] d0, d1, d2, d3;
  logic [3:0] dp;
  logic       frame_valid, seq_err, dec_err, stale;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp(dp),
    .frame_valid(frame_valid), .seq_err(seq_err), .dec_err(dec_err),
    .stale(stale), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [24:0] exp_q[$];          // {d0,d1,d2,d3,dp,dec_err}
  logic [24:0] last_frame;
  int          exp_seq = 0;
  int          act_seq = 0;
  bit          mon_en  = 1'b0;

  localparam logic [24:0] RESET_FRAME = {5'd23, 5'd23, 5'd23, 5'd23, 4'b0000, 1'b0};

  // Reference glyph patterns (active low, g..a) for 0..F.
  logic [6:0] dig_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  localparam logic [6:0] P1 = 7'h79, P2 = 7'h24, P3 = 7'h30, P4 = 7'h19;
  localparam logic [6:0] PF = 7'h0E, PBL = 7'h7F, PH = 7'h09, PR = 7'h2F;
  localparam logic [6:0] PA = 7'h08, PBAD = 7'h2A, P5 = 7'h12;

  function automatic logic [4:0] model_decode(input logic [6:0] p);
    model_decode = 5'd31;
    for (int i = 0; i < 16; i++) if (p == dig_pat[i]) model_decode = 5'(i);
    for (int k = 0; k < 7; k++) if (p == (7'h7F ^ (7'h01 << k))) model_decode = 5'(16 + k);
    if (p == 7'h7F) model_decode = 5'd23;
    if (p == 7'h09) model_decode = 5'd24;
    if (p == 7'h47) model_decode = 5'd25;
    if (p == 7'h4F) model_decode = 5'd27;
    if (p == 7'h2F) model_decode = 5'd28;
  endfunction

  function automatic logic [6:0] pick_pat(input int j);
    logic [6:0] extra [5];
    extra = '{7'h7F, 7'h09, 7'h47, 7'h4F, 7'h2F};
    if (j < 16)      pick_pat = dig_pat[j];
    else if (j < 23) pick_pat = 7'h7F ^ (7'h01 << (j - 16));
    else             pick_pat = extra[j - 23];
  endfunction

  function automatic logic [3:0] anode_of(input int i);
    anode_of = 4'(15 - (1 << i));
  endfunction

  // ---------------- reference model (dwell level) ----------------
  bit         m_track;
  bit         m_pending;
  int         m_k;
  logic [4:0] fr_code [4];
  logic [3:0] fr_dp;
  bit         fr_bad;

  task automatic model_reset();
    m_track    = 1'b0;
    m_pending  = 1'b0;
    m_k        = 0;
    last_frame = RESET_FRAME;
  endtask

  task automatic take(input int i, input logic [7:0] s);
    logic [4:0] c;
    c = model_decode(s[6:0]);
    m_track = 1'b1;
    m_k     = i;
    if (i == 0) fr_bad = 1'b0;
    fr_code[i] = c;
    fr_dp[i]   = ~s[7];
    if (c == 5'd31) fr_bad = 1'b1;
    if (i == 3) exp_q.push_back({fr_code[0], fr_code[1], fr_code[2], fr_code[3], fr_dp, fr_bad});
  endtask

  // Each dwell must show the next digit. The dwell must last long enough
  // to settle (SETTLE+1 cycles). An unsettled dwell errors at the next
  // anode change.
  task automatic model_dwell(input logic [3:0] a, input logic [7:0] s, input int len);
    bit ok, handled;
    ok      = (len >= SETTLE + 1);
    handled = 1'b0;
    if (m_pending) begin
      exp_seq++;
      m_track   = 1'b0;
      m_pending = 1'b0;
    end else if (m_track) begin
      if (a == anode_of((m_k + 1) % 4)) begin
        handled = 1'b1;
        if (ok) take((m_k + 1) % 4, s);
        else m_pending = 1'b1;
      end else begin
        exp_seq++;
        m_track = 1'b0;
      end
    end
    if (!handled && !m_track && a == 4'b1110 && ok) take(0, s);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_dwell(input logic [3:0] a, input logic [7:0] s, input int len, input bit glitch);
    model_dwell(a, s, len);
    an  = a;
    seg = s;
    for (int c = 0; c < len; c++) begin
      if (glitch && c == 4) seg = s ^ 8'h41;
      @(posedge clk); #1;
    end
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                      input logic [6:0] p3, input logic [3:0] dpm, input int len);
    drive_dwell(4'b1110, {~dpm[0], p0}, len, 1'b0);
    drive_dwell(4'b1101, {~dpm[1], p1}, len, 1'b0);
    drive_dwell(4'b1011, {~dpm[2], p2}, len, 1'b0);
    drive_dwell(4'b0111, {~dpm[3], p3}, len, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic drain();
    repeat (4) begin @(posedge clk); #1; end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    check("drain_pending_frames", exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [24:0] got, e;
    if (mon_en && reset) begin
      if (frame_valid) begin
        got = {d0, d1, d2, d3, dp, dec_err};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL frame_unexpected: got 0x%0h with no frame expected", got);
        end else begin
          e = exp_q.pop_front();
          last_frame = e;
          if (got !== e) begin
            fails++;
            $display("FAIL frame: got 0x%0h expected 0x%0h", got, e);
          end
        end
      end
      if (seq_err) begin
        act_seq++;
        tests++;
        if ({d0, d1, d2, d3, dp} !== last_frame[24:1]) begin
          fails++;
          $display("FAIL seq_err_hold: got 0x%0h expected 0x%0h", {d0, d1, d2, d3, dp}, last_frame[24:1]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          base, gen_idx, len, r;
    logic [3:0]  a, prev_an;
    logic [6:0]  p;
    bit          glitch;

    model_reset();
    an    = 4'hF;
    seg   = 8'hFF;
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d0", d0, 23); check("rst_d1", d1, 23);
    check("rst_d2", d2, 23); check("rst_d3", d3, 23);
    check("rst_dp", dp, 0);  check("rst_frame_valid", frame_valid, 0);
    check("rst_seq_err", seq_err, 0); check("rst_dec_err", dec_err, 0);
    check("rst_stale", stale, 0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Basic scan, decimal point on digit 2, two back-to-back frames.
    scan(P1, P2, P3, P4, 4'b0100, 5);
    scan(P1, P2, P3, P4, 4'b0100, 5);
    drain();
    check("basic_d0", d0, 1); check("basic_d1", d1, 2);
    check("basic_d2", d2, 3); check("basic_d3", d3, 4);
    check("basic_dp", dp, 4'b0100); check("basic_dec_err", dec_err, 0);

    // Special glyphs, and A decoding to 10.
    scan(PF, PBL, PH, PR, 4'b0000, 5);
    drain();
    check("glyph_d0_F", d0, 15); check("glyph_d1_blank", d1, 23);
    check("glyph_d2_H", d2, 24); check("glyph_d3_r", d3, 28);
    check("glyph_dec_err", dec_err, 0);
    scan(PA, P1, P2, P3, 4'b0000, 5);
    drain();
    check("glyph_A_is_10", d0, 10);

    // Bad pattern on digit 1, then a clean frame clears dec_err.
    scan(P1, PBAD, P3, P4, 4'b0000, 5);
    drain();
    check("bad_d1", d1, 31); check("bad_dec_err_set", dec_err, 1);
    scan(P1, P2, P3, P4, 4'b0000, 5);
    drain();
    check("clean_dec_err_clear", dec_err, 0);

    // Out-of-order anode: 1110 -> 1011.
    base = act_seq;
    drive_dwell(4'b1110, {1'b1, P5}, 5, 1'b0);
    drive_dwell(4'b1011, {1'b1, P3}, 5, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("order_seq_err_pulses", act_seq - base, 1);
    check("order_d0_held", d0, 1);
    scan(P4, P3, P2, P1, 4'b1001, 5);
    drain();
    check("order_rescan_d0", d0, 4); check("order_rescan_dp", dp, 4'b1001);

    // One-cycle dwells cannot settle.
    base = act_seq;
    scan(P2, P2, P2, P2, 4'b0000, 1);
    repeat (3) begin @(posedge clk); #1; end
    check("short_seq_err_pulses", act_seq - base, 1);
    check("short_no_frame_d0", d0, 4);

    // Stale: hold the anodes steady past TIMEOUT.
    model_dwell(4'b1110, {1'b1, P5}, 60);
    an  = 4'b1110;
    seg = {1'b1, P5};
    repeat (30) begin @(posedge clk); #1; end
    check("stale_not_yet", stale, 0);
    repeat (30) begin @(posedge clk); #1; end
    check("stale_set", stale, 1);
    drive_dwell(4'b1101, {1'b1, P5}, 5, 1'b0);
    check("stale_cleared", stale, 0);
    drive_dwell(4'b1011, {1'b1, P5}, 5, 1'b0);
    drive_dwell(4'b0111, {1'b1, P5}, 5, 1'b0);
    drain();
    check("stale_frame_d3", d3, 5);

    // Reset in the middle of digit 2 discards the partial frame.
    drive_dwell(4'b1110, {1'b1, P1}, 5, 1'b0);
    drive_dwell(4'b1101, {1'b1, P2}, 5, 1'b0);
    an  = 4'b1011;
    seg = {1'b0, P3};
    repeat (2) @(posedge clk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("midrst_d0", d0, 23); check("midrst_d3", d3, 23);
    check("midrst_dp", dp, 0);  check("midrst_frame_valid", frame_valid, 0);
    check("midrst_dec_err", dec_err, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    scan(P3, P4, P1, P2, 4'b0010, 5);
    drain();
    check("postrst_d0", d0, 3); check("postrst_dp", dp, 4'b0010);

    // Randomized dwells: mostly in-order scans with occasional wrong anodes,
    // unsettled dwells, bad patterns and post-sample segment glitches.
    prev_an = an;
    gen_idx = 3;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) a = 4'($urandom_range(0, 15));
      else       a = anode_of((gen_idx + 1) % 4);
      while (a == prev_an) a = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) if (a == anode_of(i)) gen_idx = i;
      len    = ($urandom_range(0, 99) < 8) ? 1 : $urandom_range(4, 7);
      glitch = (len >= 6) && ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 85) p = pick_pat($urandom_range(0, 27));
      else                            p = 7'($urandom_range(0, 127));
      drive_dwell(a, {1'($urandom_range(0, 1)), p}, len, glitch);
      prev_an = a;
    end
    repeat (6) begin @(posedge clk); #1; end
    drain();
    check("seq_err_count", act_seq, exp_seq);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning consecutive identical {an,seg} cycles required before a digit is sampled (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 20'd500_000, meaning cycles without any anode change before the display is flagged stale.
REQ-003 SHALL have port clk, input, 1 bit, 100 MHz system clock; all other inputs are synchronous to clk.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port an, input, 4 bits, display anode bus, active-low one-hot (1110 = digit 0 ... 0111 = digit 3).
REQ-006 SHALL have port seg, input, 8 bits, display cathode bus, active-low; seg[7] is the decimal point, seg[6:0] are segments g..a.
REQ-007 SHALL have ports d0, d1, d2, d3, output, 5 bits each, recovered digit codes for digits 0..3.
REQ-008 SHALL have port dp, output, 4 bits, recovered decimal points, active-high, bit n = digit n.
REQ-009 SHALL have port frame_valid, output, 1 bit, one-cycle pulse when d0..d3/dp are updated.
REQ-010 SHALL have port seq_err, output, 1 bit, one-cycle pulse on an illegal anode sequence.
REQ-011 SHALL have port dec_err, output, 1 bit, sticky flag set when any sampled seg[6:0] is not in the decode table; cleared on each frame_valid whose frame decoded cleanly.
REQ-012 SHALL have port stale, output, 1 bit, level high while no anode change has occurred for TIMEOUT cycles.

Function
REQ-013 SHALL register an and seg once on input; all decisions use the registered values ({an_q,seg_q}).
REQ-014 SHALL keep a stability counter, cleared whenever {an_q,seg_q} differs from its previous-cycle value, incremented otherwise, saturating at SETTLE.
REQ-015 SHALL implement states SYNC, DWELL, WAIT_CHG with a 2-bit digit index idx.
REQ-016 SYNC: when an_q == 1110 and stability counter == SETTLE, sample into shadow[0], idx=0, go to WAIT_CHG.
REQ-017 DWELL: an_q must equal expected[idx]; when stability counter reaches SETTLE, sample into shadow[idx], go to WAIT_CHG.
REQ-018 WAIT_CHG: seg changes with an_q unchanged are ignored; when an_q changes to expected[idx+1 mod 4], idx increments (wrapping 3->0), go to DWELL.
REQ-019 Any an_q change to a value other than expected[idx+1 mod 4] (including non-one-hot, 1111, or repeated digit), or an an_q change while in DWELL before sampling, SHALL pulse seq_err for one cycle and go to SYNC; d0..d3/dp hold.
REQ-020 Decode table (seg[6:0] -> code): 0-9 and A-F patterns -> 0..15; single segments a..g -> 16..22; 1111111 -> 23; H 0001001 -> 24; L 1000111 -> 25; l 1001111 -> 27; r 0101111 -> 28; pattern 0001000 SHALL decode to 10 (A), never 26; any other pattern -> 31 and sets the frame's error flag.
REQ-021 Sampling shadow[idx] stores code and dp bit = ~seg_q[7].
REQ-022 On sampling idx 3, the next cycle SHALL copy shadow[0..3] to d0..d3 and dp simultaneously and pulse frame_valid for exactly one cycle; latency from idx-3 sample to frame_valid = 1 cycle.
REQ-023 Timeout counter SHALL clear on every an_q change and saturate at TIMEOUT; stale = (counter == TIMEOUT); stale does not alter the state machine.
REQ-024 A simultaneous seq_err condition and stale assertion SHALL both be reported; seq_err has priority over sampling in the same cycle.

Reset
REQ-025 On reset low, asynchronously: state=SYNC, idx=0, counters=0, d0..d3=5'd23, dp=4'b0000, frame_valid=0, seq_err=0, dec_err=0, stale=0, shadows=23.
REQ-026 Reset asserted mid-frame SHALL discard partial shadow contents; first frame_valid after release requires a complete 0-1-2-3 scan starting at SYNC.

Verification
REQ-027 Scan an 1110/1101/1011/0111 with seg patterns for 1,2,3,4, dp on digit 2, dwell 5 cycles each -> frame_valid pulse once per scan, d0..d3=1,2,3,4, dp=0100.
REQ-028 Scan codes F, 23 (blank), H, r -> d=15,23,24,28, dec_err=0; seg 0001000 -> 10.
REQ-029 Inject seg 0101010 on digit 1 -> that d=31, dec_err=1 after frame_valid; next clean frame clears dec_err.
REQ-030 Anode order 1110 -> 1011 -> seq_err pulse, outputs hold, frame_valid only after next full scan.
REQ-031 Dwell of 1 cycle per digit with SETTLE=2 -> seq_err, no frame_valid; hold an constant TIMEOUT cycles -> stale=1, clears on next an change.
REQ-032 Assert reset during digit 2 -> outputs 23/dp=0 immediately; after release, frame_valid only after full new scan.
